// File: rtl/fetch_sequencer_if.sv
// Handshake bundle between fetch_sequencer, instruction memory and the execute datapath.
interface fetch_sequencer_if;
  logic        imem_req;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        stall;
  logic        branch_taken;
  logic [2:0]  pc_control;
  logic        pc_we;
  logic [31:0] retired;
  logic        fetch_error;

  modport master (
    output imem_req, instr, instr_valid, pc_control, pc_we, retired, fetch_error,
    input  imem_ack, imem_rdata, stall, branch_taken
  );

  modport slave (
    input  imem_req, instr, instr_valid, pc_control, pc_we, retired, fetch_error,
    output imem_ack, imem_rdata, stall, branch_taken
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Multicycle fetch/execute/PC-update sequencer with registered (Moore) outputs.
// Define FETCH_TIMEOUT_EN to build the imem timeout counter and sticky ERROR state.
module fetch_sequencer #(
  parameter int unsigned IMEM_TIMEOUT = 255
) (
  input logic               clk,
  input logic               rst,
  fetch_sequencer_if.master bus
);

  if (IMEM_TIMEOUT < 1 || IMEM_TIMEOUT > 65535) begin : g_bad_timeout
    $error("IMEM_TIMEOUT out of range 1..65535");
  end

`ifdef FETCH_TIMEOUT_EN
  typedef enum logic [2:0] {IDLE, FETCH, EXEC, UPDATE, ERROR} state_t;
  // Count of ack-less FETCH cycles already seen; the limit hits on the cycle that would make it IMEM_TIMEOUT.
  localparam logic [15:0] TO_LAST = 16'(IMEM_TIMEOUT - 1);
  logic [15:0] cnt_q;
`else
  typedef enum logic [2:0] {IDLE, FETCH, EXEC, UPDATE} state_t;
`endif

  state_t      state_q;
  logic        imem_req_q;
  logic [31:0] instr_q;
  logic        instr_valid_q;
  logic [2:0]  pc_control_q;
  logic        pc_we_q;
  logic [31:0] retired_q;
  logic        fetch_error_q;

  function automatic logic [2:0] next_pc_class(input logic [31:0] ir, input logic bt);
    logic [2:0] cls;
    cls = 3'b000;
    unique case (ir[31:26])
      6'b000010, 6'b000011: cls = 3'b001;
      6'b000000:            if (ir[5:0] == 6'b001000 || ir[5:0] == 6'b001001) cls = 3'b010;
      6'b000100, 6'b000101: if (bt) cls = 3'b011;
      default:              cls = 3'b000;
    endcase
    return cls;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      imem_req_q    <= 1'b0;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      pc_control_q  <= 3'b000;
      pc_we_q       <= 1'b0;
      retired_q     <= '0;
      fetch_error_q <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      cnt_q         <= '0;
`endif
    end else begin
      // UPDATE strobes are single-cycle by construction.
      pc_we_q      <= 1'b0;
      pc_control_q <= 3'b000;
      unique case (state_q)
        IDLE: begin
          state_q    <= FETCH;
          imem_req_q <= 1'b1;
`ifdef FETCH_TIMEOUT_EN
          cnt_q      <= '0;
`endif
        end
        FETCH: begin
          if (bus.imem_ack) begin
            state_q       <= EXEC;
            instr_q       <= bus.imem_rdata;
            imem_req_q    <= 1'b0;
            instr_valid_q <= 1'b1;
          end
`ifdef FETCH_TIMEOUT_EN
          else if (cnt_q == TO_LAST) begin
            state_q       <= ERROR;
            imem_req_q    <= 1'b0;
            fetch_error_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
`endif
        end
        EXEC: begin
          if (!bus.stall) begin
            state_q       <= UPDATE;
            instr_valid_q <= 1'b0;
            pc_we_q       <= 1'b1;
            pc_control_q  <= next_pc_class(instr_q, bus.branch_taken);
            retired_q     <= retired_q + 32'd1;
          end
        end
        UPDATE: begin
          state_q    <= FETCH;
          imem_req_q <= 1'b1;
`ifdef FETCH_TIMEOUT_EN
          cnt_q      <= '0;
`endif
        end
`ifdef FETCH_TIMEOUT_EN
        ERROR: state_q <= ERROR;
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.imem_req    = imem_req_q;
  assign bus.instr       = instr_q;
  assign bus.instr_valid = instr_valid_q;
  assign bus.pc_control  = pc_control_q;
  assign bus.pc_we       = pc_we_q;
  assign bus.retired     = retired_q;
  assign bus.fetch_error = fetch_error_q;

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Multicycle instruction-fetch controller that sequences the program counter. It fetches each instruction from instruction memory over a req/ack handshake and holds it for the execute stage. It then resolves the next-PC class (sequential, J, JR, BEQ/BNE) and issues a one-cycle `pc_we` strobe with the matching `pc_control` code. It sits between the instruction memory port, the decode/execute datapath and the program counter; the program counter advances only when `pc_we` is high.

## Interface
- `IMEM_TIMEOUT`, default 255: max cycles `imem_req` may stay high without `imem_ack` before a fetch error; legal range 1..65535.
- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `imem_req`  out  1  fetch request to instruction memory.
- `imem_ack`  in  1  memory ack; `imem_rdata` valid in the same cycle.
- `imem_rdata`  in  32  fetched instruction word.
- `instr`  out  32  latched instruction for decode/execute.
- `instr_valid`  out  1  `instr` is held for execute.
- `stall`  in  1  execute busy; holds the sequencer in EXEC.
- `branch_taken`  in  1  compare result for BEQ/BNE; sampled on EXEC exit.
- `pc_control`  out  3  next-PC select; meaningful only while `pc_we` = 1, else 000.
- `pc_we`  out  1  one-cycle PC update strobe.
- `retired`  out  32  count of completed PC updates; wraps 0xFFFFFFFF -> 0.
- `fetch_error`  out  1  sticky memory-timeout flag.

## Operation
- States: IDLE, FETCH, EXEC, UPDATE, ERROR. Encoding is free.
- IDLE: entered on reset. Goes to FETCH on the next edge unconditionally.
- FETCH: `imem_req` = 1. On `imem_ack` = 1, capture `imem_rdata` into `instr` and go to EXEC. `imem_ack` is ignored in all other states.
- EXEC: `instr_valid` = 1. While `stall` = 1, stay in EXEC. When `stall` = 0, latch the next-PC class into a registered `pc_control` and go to UPDATE.
- Next-PC class decode, using op = `instr[31:26]` and fn = `instr[5:0]`:
  - op 000010 (J) or 000011 (JAL) -> 001.
  - op 000000 with fn 001000 (JR) or 001001 (JALR) -> 010.
  - op 000100 (BEQ) or 000101 (BNE) with `branch_taken` = 1 -> 011. With `branch_taken` = 0 -> 000.
  - All other opcodes -> 000.
- UPDATE: `pc_we` = 1 and `pc_control` is driven for exactly one cycle. `retired` increments. Next state is FETCH.
- ERROR: all handshake outputs are 0 and `fetch_error` = 1. The only exit is `rst`.

## Timing
- Reset values: `imem_req` 0, `instr` 0, `instr_valid` 0, `pc_control` 000, `pc_we` 0, `retired` 0, `fetch_error` 0, state IDLE.
- Reset is asynchronous. Asserting `rst` mid-fetch or mid-UPDATE clears all outputs immediately, and any pending update is discarded.
- Outputs are Moore (registered state decode), with no combinational path from inputs to outputs.
- Minimum instruction period is 3 cycles: FETCH with ack in its first cycle, then EXEC with `stall` = 0, then UPDATE.
- `pc_we` is never high in two consecutive cycles.
- `instr` is stable from the EXEC entry edge through the end of UPDATE.
- `branch_taken` is sampled only on the edge that leaves EXEC.
- Timeout counter:
  - Cleared on FETCH entry; counts each FETCH cycle with `imem_ack` = 0.
  - When the count reaches `IMEM_TIMEOUT`, the next state is ERROR.
  - If `imem_ack` = 1 in the same cycle the limit is reached, the ack wins and the state goes to EXEC.

## Configuration
- `FETCH_TIMEOUT_EN` defined: the timeout counter and ERROR state are compiled in as described above.
- `FETCH_TIMEOUT_EN` undefined:
  - No counter or ERROR state is built, and FETCH waits indefinitely for `imem_ack`.
  - `fetch_error` is tied to 0.
  - `IMEM_TIMEOUT` is unused.

## Test plan
- Reset, then ack in the first FETCH cycle with 0x00000000 (nop), `stall` = 0 -> `pc_we` pulses on cycle 3 with `pc_control` = 000, `retired` = 1, and `imem_req` rises again on cycle 4.
- Fetch 0x08000010 (J) -> `pc_control` = 001 with `pc_we`. Fetch 0x03E00008 (JR $ra) -> `pc_control` = 010.
- Fetch 0x10220004 (BEQ):
  - `branch_taken` = 1 -> `pc_control` = 011.
  - Repeat with `branch_taken` = 0 -> 000.
  - `branch_taken` toggling during `stall` = 1 has no effect; only the value on EXEC exit counts.
- Fetch, then hold `stall` = 1 for 5 cycles -> `instr_valid` stays high for 6 cycles with `instr` unchanged; a single `pc_we` pulse follows.
- With `FETCH_TIMEOUT_EN` and `IMEM_TIMEOUT` = 4:
  - No ack -> `fetch_error` = 1 after 4 request cycles, and `imem_req` = 0 afterwards.
  - Ack on the 4th cycle -> normal EXEC, no error.
- Assert `rst` during UPDATE -> `pc_we` and `retired` drop to 0 immediately; the sequence restarts from IDLE after release.
